// File: rtl/ir_capture_controller_pkg.sv
// Shared types, defaults and helpers for the impulse-response capture controller.
package ir_capture_controller_pkg;

    localparam int IR_ADDR_W = 16;
    localparam int IR_DATA_W = 16;

    localparam logic [15:0] IMPULSE_LENGTH_DEF  = 16'd24000;
    localparam logic [15:0] TIMEOUT_SAMPLES_DEF = 16'd40000;
    localparam logic [15:0] SETTLE_SAMPLES_DEF  = 16'd480;
    localparam int          READ_LATENCY_DEF    = 2;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        DRAIN    = 3'd1,
        TRIGGER  = 3'd2,
        WAIT_REC = 3'd3,
        SETTLE   = 3'd4
    } ir_ctrl_state;

    // Counters stick at all-ones instead of wrapping.
    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        sat_inc = (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/ir_capture_controller_if.sv
// Recorder, convolver and IR BRAM signals shared by the capture controller.
interface ir_capture_controller_if;
    import ir_capture_controller_pkg::*;

    logic                        rec_impulse_recorded;
    logic                        rec_write_enable;
    logic                        rec_data_valid;
    logic [IR_ADDR_W-1:0]        rec_sample_index;
    logic signed [IR_DATA_W-1:0] rec_write_data;

    logic                        conv_req;
    logic [IR_ADDR_W-1:0]        conv_addr;
    logic                        conv_grant;
    logic signed [IR_DATA_W-1:0] conv_rdata;
    logic                        conv_rdata_valid;

    logic [IR_ADDR_W-1:0]        bram_addr;
    logic signed [IR_DATA_W-1:0] bram_din;
    logic                        bram_we;
    logic signed [IR_DATA_W-1:0] bram_dout;

    modport slave (
        input  rec_impulse_recorded, rec_write_enable, rec_data_valid,
               rec_sample_index, rec_write_data, conv_req, conv_addr, bram_dout,
        output bram_addr, bram_din, bram_we, conv_grant, conv_rdata, conv_rdata_valid
    );

    modport master (
        output rec_impulse_recorded, rec_write_enable, rec_data_valid,
               rec_sample_index, rec_write_data, conv_req, conv_addr, bram_dout,
        input  bram_addr, bram_din, bram_we, conv_grant, conv_rdata, conv_rdata_valid
    );

endinterface

// File: rtl/ir_capture_controller_read_valid_pipe.sv
// Grant-bit shift register that marks when BRAM read data reaches the convolver.
module ir_capture_controller_read_valid_pipe #(
    parameter int DEPTH = 2
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic valid_i,
    output logic valid_o,
    output logic empty_o
);

    logic [DEPTH-1:0] pipe_q;
    logic [DEPTH-1:0] pipe_d;

    // Shift a new grant bit in at the head each clock.
    always_comb begin
        pipe_d = (pipe_q << 1) | DEPTH'(valid_i);
    end

    // Pipeline register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pipe_q <= {DEPTH{1'b0}};
        end else begin
            pipe_q <= pipe_d;
        end
    end

    assign valid_o = pipe_q[DEPTH-1];
    assign empty_o = (pipe_q == {DEPTH{1'b0}});

endmodule

// File: rtl/ir_capture_controller.sv
// Runs one impulse-response capture (trigger, supervise, settle) and shares the
// single IR BRAM port between recorder writes and convolver reads.
module ir_capture_controller
    import ir_capture_controller_pkg::*;
#(
    parameter logic [15:0] IMPULSE_LENGTH  = IMPULSE_LENGTH_DEF,
    parameter logic [15:0] TIMEOUT_SAMPLES = TIMEOUT_SAMPLES_DEF,
    parameter logic [15:0] SETTLE_SAMPLES  = SETTLE_SAMPLES_DEF,
    parameter int          READ_LATENCY    = READ_LATENCY_DEF
) (
    input  logic                          audio_clk,
    input  logic                          rst_in,
    input  logic                          audio_trigger_i,
    input  logic                          start_measure_i,
    ir_capture_controller_if.slave        bus,
    output logic                          record_impulse_trigger_o,
    output logic                          ir_ready_o,
    output logic                          busy_o,
    output logic                          timeout_err_o
);

    ir_ctrl_state                state_q, state_d;
    logic [15:0]                 write_count_q, write_count_d;
    logic [15:0]                 tmo_count_q, tmo_count_d;
    logic [15:0]                 settle_count_q, settle_count_d;
    logic [IR_ADDR_W-1:0]        bram_addr_q, bram_addr_d;
    logic signed [IR_DATA_W-1:0] bram_din_q, bram_din_d;
    logic                        bram_we_q, bram_we_d;
    logic                        ir_ready_q, ir_ready_d;
    logic                        timeout_err_q, timeout_err_d;
    logic                        grant_s;
    logic                        pipe_empty_s;
    logic                        rec_write_s;
    logic [15:0]                 tmo_next_s;
    logic [15:0]                 settle_next_s;

    assign rec_write_s   = bus.rec_write_enable & bus.rec_data_valid;
    assign tmo_next_s    = audio_trigger_i ? sat_inc(tmo_count_q) : tmo_count_q;
    assign settle_next_s = audio_trigger_i ? sat_inc(settle_count_q) : settle_count_q;

    // Next-state, counter and BRAM-port decisions.
    always_comb begin
        state_d        = state_q;
        write_count_d  = write_count_q;
        tmo_count_d    = tmo_count_q;
        settle_count_d = settle_count_q;
        bram_addr_d    = bram_addr_q;
        bram_din_d     = bram_din_q;
        bram_we_d      = 1'b0;
        ir_ready_d     = ir_ready_q;
        timeout_err_d  = timeout_err_q;
        grant_s        = 1'b0;

        case (state_q)
            IDLE: begin
                if (start_measure_i) begin
                    state_d       = DRAIN;
                    ir_ready_d    = 1'b0;
                    timeout_err_d = 1'b0;
                end else if (bus.conv_req) begin
                    grant_s     = 1'b1;
                    bram_addr_d = bus.conv_addr;
                end else begin
                    grant_s = 1'b0;
                end
            end
            DRAIN: begin
                if (pipe_empty_s) begin
                    state_d = TRIGGER;
                end else begin
                    state_d = DRAIN;
                end
            end
            TRIGGER: begin
                write_count_d = 16'd0;
                tmo_count_d   = 16'd0;
                state_d       = WAIT_REC;
            end
            WAIT_REC: begin
                // Out-of-range recorder addresses are silently dropped.
                if (rec_write_s && (bus.rec_sample_index < IMPULSE_LENGTH)) begin
                    bram_we_d     = 1'b1;
                    bram_addr_d   = bus.rec_sample_index;
                    bram_din_d    = bus.rec_write_data;
                    write_count_d = sat_inc(write_count_q);
                end else begin
                    bram_we_d = 1'b0;
                end
                tmo_count_d = tmo_next_s;
                if (bus.rec_impulse_recorded) begin
                    if (write_count_q == IMPULSE_LENGTH) begin
                        state_d        = SETTLE;
                        settle_count_d = 16'd0;
                    end else begin
                        state_d       = IDLE;
                        timeout_err_d = 1'b1;
                    end
                end else if (tmo_next_s >= TIMEOUT_SAMPLES) begin
                    state_d       = IDLE;
                    timeout_err_d = 1'b1;
                end else begin
                    state_d = WAIT_REC;
                end
            end
            SETTLE: begin
                settle_count_d = settle_next_s;
                if (settle_next_s >= SETTLE_SAMPLES) begin
                    state_d    = IDLE;
                    ir_ready_d = 1'b1;
                end else begin
                    state_d = SETTLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, counters and registered BRAM/status outputs.
    always_ff @(posedge audio_clk) begin
        if (rst_in) begin
            state_q        <= IDLE;
            write_count_q  <= 16'd0;
            tmo_count_q    <= 16'd0;
            settle_count_q <= 16'd0;
            bram_addr_q    <= {IR_ADDR_W{1'b0}};
            bram_din_q     <= {IR_DATA_W{1'b0}};
            bram_we_q      <= 1'b0;
            ir_ready_q     <= 1'b0;
            timeout_err_q  <= 1'b0;
        end else begin
            state_q        <= state_d;
            write_count_q  <= write_count_d;
            tmo_count_q    <= tmo_count_d;
            settle_count_q <= settle_count_d;
            bram_addr_q    <= bram_addr_d;
            bram_din_q     <= bram_din_d;
            bram_we_q      <= bram_we_d;
            ir_ready_q     <= ir_ready_d;
            timeout_err_q  <= timeout_err_d;
        end
    end

    ir_capture_controller_read_valid_pipe #(
        .DEPTH (READ_LATENCY)
    ) u_read_valid_pipe (
        .clk_i   (audio_clk),
        .rst_i   (rst_in),
        .valid_i (grant_s),
        .valid_o (bus.conv_rdata_valid),
        .empty_o (pipe_empty_s)
    );

    assign bus.conv_grant           = grant_s;
    assign bus.conv_rdata           = bus.bram_dout;
    assign bus.bram_addr            = bram_addr_q;
    assign bus.bram_din             = bram_din_q;
    assign bus.bram_we              = bram_we_q;
    assign record_impulse_trigger_o = (state_q == TRIGGER);
    assign busy_o                   = (state_q != IDLE);
    assign ir_ready_o               = ir_ready_q;
    assign timeout_err_o            = timeout_err_q;

endmodule

// File: tb/tb_ir_capture_controller.sv
// Randomized scoreboard bench for ir_capture_controller with a small BRAM model.
module tb_ir_capture_controller;
    import ir_capture_controller_pkg::*;

    localparam logic [15:0] IL = 16'd8;
    localparam logic [15:0] SS = 16'd4;
    localparam logic [15:0] TO = 16'd10;

    typedef struct { int addr; int data; } wr_t;
    typedef struct { int data; int cyc; } rd_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic atrig = 1'b0;
    logic start = 1'b0;
    logic rec_trig, ir_ready, busy, terr;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int trig_pulses = 0;
    logic pend_v = 1'b0;
    int pend_addr = 0;
    wr_t exp_wr[$];
    rd_t exp_rd[$];
    logic signed [15:0] mem [0:255];

    ir_capture_controller_if bus();

    ir_capture_controller #(
        .IMPULSE_LENGTH  (IL),
        .TIMEOUT_SAMPLES (TO),
        .SETTLE_SAMPLES  (SS),
        .READ_LATENCY    (2)
    ) dut (
        .audio_clk                (clk),
        .rst_in                   (rst),
        .audio_trigger_i          (atrig),
        .start_measure_i          (start),
        .bus                      (bus.slave),
        .record_impulse_trigger_o (rec_trig),
        .ir_ready_o               (ir_ready),
        .busy_o                   (busy),
        .timeout_err_o            (terr)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // BRAM model: one registered read stage, writes land on the clock edge.
    always @(posedge clk) begin
        if (bus.bram_we) mem[bus.bram_addr[7:0]] <= bus.bram_din;
        bus.bram_dout <= mem[bus.bram_addr[7:0]];
    end

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Audio sample strobe every 4..8 clocks.
    initial begin
        forever begin
            repeat ($urandom_range(8, 4)) @(posedge clk);
            #1 atrig = 1'b1;
            @(posedge clk);
            #1 atrig = 1'b0;
        end
    end

    // Monitor: pops expected writes/reads when the DUT presents them.
    initial begin
        rd_t r;
        wr_t w;
        forever begin
            @(negedge clk);
            if (pend_v) begin
                chk("bram_addr_after_grant", int'(bus.bram_addr), pend_addr);
                pend_v = 1'b0;
            end
            if (bus.conv_grant) begin
                chk("grant_only_when_idle", int'(busy), 0);
                exp_rd.push_back('{data: int'(mem[bus.conv_addr[7:0]]), cyc: cyc});
                pend_v = 1'b1;
                pend_addr = int'(bus.conv_addr);
            end
            if (bus.conv_rdata_valid) begin
                if (exp_rd.size() == 0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL unexpected_rdata_valid: got valid expected none");
                end else begin
                    r = exp_rd.pop_front();
                    chk("rd_latency", cyc - r.cyc, 2);
                    chk("rd_data", int'(bus.conv_rdata), r.data);
                end
            end
            if (bus.bram_we) begin
                if (exp_wr.size() == 0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL unexpected_write: got we addr %0d expected no write", bus.bram_addr);
                end else begin
                    w = exp_wr.pop_front();
                    chk("wr_addr", int'(bus.bram_addr), w.addr);
                    chk("wr_data", int'(bus.bram_din), w.data);
                end
            end
            if (rec_trig) trig_pulses++;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic do_read(input int a);
        @(posedge clk); #1;
        bus.conv_req = 1'b1;
        bus.conv_addr = 16'(a);
        @(negedge clk);
        chk("idle_grant", int'(bus.conv_grant), 1);
        @(posedge clk); #1;
        bus.conv_req = 1'b0;
    endtask

    task automatic start_pulse(input logic with_req);
        @(posedge clk); #1;
        start = 1'b1;
        bus.conv_req = with_req;
        bus.conv_addr = 16'd5;
        @(negedge clk);
        chk("start_beats_req", int'(bus.conv_grant), 0);
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        chk("busy_after_start", int'(busy), 1);
        chk("ir_ready_cleared", int'(ir_ready), 0);
        chk("terr_cleared", int'(terr), 0);
    endtask

    task automatic wait_trig();
        int n = 0;
        while (!rec_trig && n < 30) begin
            @(negedge clk);
            n++;
        end
        chk("record_trigger_seen", int'(rec_trig), 1);
    endtask

    task automatic do_write(input int idx);
        logic signed [15:0] d;
        d = 16'($urandom);
        if ($urandom_range(1, 0) == 1) begin
            @(posedge clk); #1;
            bus.rec_write_enable = 1'b1;
            bus.rec_data_valid = 1'b0;
        end
        @(posedge clk); #1;
        bus.rec_write_enable = 1'b1;
        bus.rec_data_valid = 1'b1;
        bus.rec_sample_index = 16'(idx);
        bus.rec_write_data = d;
        if (idx < int'(IL)) exp_wr.push_back('{addr: idx, data: int'(d)});
        @(posedge clk); #1;
        bus.rec_write_enable = 1'b0;
        bus.rec_data_valid = 1'b0;
    endtask

    task automatic run_measure(input int n_wr, input logic with_bad, input logic poke, input logic hold_req);
        int cnt = 0;
        int guard = 0;
        logic poked = 1'b0;
        trig_pulses = 0;
        start_pulse(hold_req);
        wait_trig();
        for (int i = 0; i < n_wr; i++) begin
            if (with_bad && i == 3) do_write(int'(IL));
            do_write(i);
        end
        @(posedge clk); #1;
        bus.rec_impulse_recorded = 1'b1;
        @(posedge clk); #1;
        bus.rec_impulse_recorded = 1'b0;
        if (n_wr == int'(IL)) begin
            while (guard < 300) begin
                @(negedge clk);
                guard++;
                if (poked) start = 1'b0;
                if (ir_ready) break;
                if (atrig) begin
                    cnt++;
                    if (poke && !poked) begin
                        start = 1'b1;
                        poked = 1'b1;
                    end
                end
            end
            start = 1'b0;
            chk("settle_trigger_count", cnt, int'(SS));
            chk("ir_ready_set", int'(ir_ready), 1);
            chk("busy_falls_with_ready", int'(busy), 0);
            chk("terr_clear_on_success", int'(terr), 0);
        end else begin
            @(negedge clk);
            chk("short_busy", int'(busy), 0);
            chk("short_terr", int'(terr), 1);
            chk("short_ir_ready", int'(ir_ready), 0);
        end
        chk("one_trigger_pulse", trig_pulses, 1);
        @(posedge clk); #1;
        bus.conv_req = 1'b0;
        repeat (3) @(posedge clk);
    endtask

    initial begin
        int cnt;
        int guard;
        for (int i = 0; i < 256; i++) mem[i] = 16'($urandom);
        bus.rec_impulse_recorded = 1'b0;
        bus.rec_write_enable = 1'b0;
        bus.rec_data_valid = 1'b0;
        bus.rec_sample_index = 16'd0;
        bus.rec_write_data = 16'sd0;
        bus.conv_req = 1'b0;
        bus.conv_addr = 16'd0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", int'(busy), 0);
        chk("rst_ir_ready", int'(ir_ready), 0);
        chk("rst_terr", int'(terr), 0);
        chk("rst_trigger", int'(rec_trig), 0);
        chk("rst_bram_we", int'(bus.bram_we), 0);
        chk("rst_bram_addr", int'(bus.bram_addr), 0);
        chk("rst_rdata_valid", int'(bus.conv_rdata_valid), 0);
        @(posedge clk); #1;
        rst = 1'b0;

        do_read(5);
        for (int i = 0; i < 5; i++) do_read($urandom_range(255, 0));

        run_measure(int'(IL), 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) do_read($urandom_range(7, 0));

        run_measure(6, 1'b1, 1'b0, 1'b0);

        // Recorder never completes.
        start_pulse(1'b0);
        wait_trig();
        cnt = 0;
        guard = 0;
        while (guard < 300) begin
            @(negedge clk);
            guard++;
            if (!busy) break;
            if (atrig) cnt++;
        end
        chk("timeout_trigger_count", cnt, int'(TO));
        chk("timeout_busy", int'(busy), 0);
        chk("timeout_terr", int'(terr), 1);
        chk("timeout_ir_ready", int'(ir_ready), 0);

        // Reset in the middle of a capture.
        start_pulse(1'b0);
        wait_trig();
        for (int i = 0; i < 3; i++) do_write(i);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_busy", int'(busy), 0);
        chk("midrst_ir_ready", int'(ir_ready), 0);
        chk("midrst_terr", int'(terr), 0);
        chk("midrst_bram_we", int'(bus.bram_we), 0);
        chk("midrst_bram_addr", int'(bus.bram_addr), 0);
        chk("midrst_bram_din", int'(bus.bram_din), 0);
        chk("midrst_wr_queue", exp_wr.size(), 0);

        run_measure(int'(IL), 1'b0, 1'b1, 1'b0);
        run_measure(int'(IL), 1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 4; i++) do_read($urandom_range(15, 0));

        repeat (6) @(negedge clk);
        chk("leftover_writes", exp_wr.size(), 0);
        chk("leftover_reads", exp_rd.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/ir_capture_controller.md
Name: ir_capture_controller

Overview:
- Sequences one impulse-response measurement end to end:
  - fires the recorder's one-shot trigger;
  - supervises it with a sample-based timeout and write-count check;
  - enforces a settle gap before the IR is declared usable.
- Also arbitrates the single IR BRAM port between the recorder (write) and the convolution engine (read).
- Sits between the user/start logic, the impulse recorder, the IR BRAM and the convolver.

Parameters:
- IMPULSE_LENGTH, 16'd24000, IR samples per measurement; also the valid address range.
- TIMEOUT_SAMPLES, 16'd40000, audio samples allowed from trigger to recorder done.
- SETTLE_SAMPLES, 16'd480, audio samples to wait after recorder done before ir_ready.
- READ_LATENCY, 2, BRAM read latency in clocks.

Ports:
- audio_clk  in  1  system clock
- rst_in  in  1  synchronous, active-high reset
- audio_trigger  in  1  one-cycle pulse per audio sample
- start_measure  in  1  one-cycle request to start a measurement
- rec_impulse_recorded  in  1  recorder done pulse
- rec_write_enable  in  1  recorder write window
- rec_data_valid  in  1  recorder sample-valid strobe
- rec_sample_index  in  16  recorder write address
- rec_write_data  in  16 signed  recorder sample
- conv_req  in  1  convolver read request
- conv_addr  in  16  convolver read address
- bram_dout  in  16 signed  BRAM read data
- record_impulse_trigger  out  1  one-cycle pulse to recorder
- bram_addr  out  16  BRAM address (registered)
- bram_din  out  16 signed  BRAM write data (registered)
- bram_we  out  1  BRAM write enable (registered)
- conv_grant  out  1  read request accepted this cycle
- conv_rdata  out  16 signed  read data to convolver
- conv_rdata_valid  out  1  conv_rdata valid
- ir_ready  out  1  BRAM holds a complete, settled IR
- busy  out  1  measurement in progress (state != IDLE)
- timeout_err  out  1  sticky: last measurement timed out or was short

Behaviour:
- Reset values: all outputs 0, state IDLE, all counters 0, read pipeline cleared.
  - Reset mid-measurement also leaves ir_ready=0, since BRAM contents are now partial.
- IDLE:
  - start_measure=1 → DRAIN; clear ir_ready and timeout_err the same cycle.
  - Otherwise grant reads: conv_grant = conv_req (combinational), and next cycle bram_addr<=conv_addr, bram_we<=0.
  - If start_measure and conv_req arrive together, start wins: no grant.
- DRAIN: no new grants. Wait until the read valid pipeline is empty (≤ READ_LATENCY clocks), then → TRIGGER.
- TRIGGER:
  - record_impulse_trigger=1 for exactly one clock.
  - Clear write_count and timeout counter.
  - → WAIT_REC.
- WAIT_REC:
  - Each cycle with rec_write_enable & rec_data_valid:
    - if rec_sample_index < IMPULSE_LENGTH: next cycle bram_we=1, bram_addr=rec_sample_index, bram_din=rec_write_data; write_count++.
    - else drop the write (bram_we=0).
  - Timeout counter increments on audio_trigger.
  - Reaching TIMEOUT_SAMPLES → IDLE, timeout_err=1.
  - rec_impulse_recorded, checked before timeout when both occur in the same cycle:
    - write_count == IMPULSE_LENGTH → SETTLE;
    - otherwise → IDLE with timeout_err=1.
- SETTLE:
  - Count audio_trigger pulses.
  - On the SETTLE_SAMPLES-th pulse → IDLE and set ir_ready=1.
  - ir_ready stays high until the next start_measure or reset.
- Read path:
  - A READ_LATENCY-deep shift register of grant bits; conv_rdata_valid is its tail.
  - conv_rdata = bram_dout, passed through.
  - Reads are granted only in IDLE, regardless of ir_ready; the convolver gates on ir_ready.
- Other rules:
  - start_measure outside IDLE is ignored.
  - All counters are 16-bit unsigned and saturate; they never wrap.
  - bram_we is never asserted outside WAIT_REC, plus the one registered cycle after it.

Decomposition:
- Shared package (audio pkg):
  - typedef enum logic [2:0] ir_ctrl_state {IDLE, DRAIN, TRIGGER, WAIT_REC, SETTLE};
  - IR_ADDR_W = 16.
- One natural sub-module: read_valid_pipe (READ_LATENCY-deep valid shift register with empty flag).

Test Plan:
- Nominal run (IMPULSE_LENGTH=8, SETTLE_SAMPLES=4): start; recorder model writes 0..7 then pulses done.
  - Required: 8 bram_we writes at addr 0..7 with matching data.
  - Required: ir_ready rises on the 4th audio_trigger after done; busy falls the same cycle.
- Arbitration: conv_req held during a measurement gets no grants. In IDLE, conv_addr=5 → bram_addr=5 next cycle, conv_rdata_valid exactly 2 clocks after grant.
  - Same-cycle start + conv_req → no grant, busy=1.
- Timeout (TIMEOUT_SAMPLES=10): recorder never completes.
  - Required: after 10 audio_triggers, state IDLE, timeout_err=1, ir_ready=0.
- Short capture: done after 6 of 8 writes → timeout_err=1, ir_ready=0. An out-of-range index 8 is dropped (no bram_we).
- Reset during WAIT_REC after 3 writes → all outputs 0 next cycle.
  - A following start yields a full nominal run.
- start_measure pulsed during SETTLE → ignored: exactly one record_impulse_trigger was issued.
